// File: rtl/csa_resolve_stage.sv
// csa_resolve_stage
//   Carry-propagate stage behind the 3:2 compressor tree. It turns a redundant
//   (sum, carry) pair into one binary result, sum + (carry << 1), truncated to
//   WIDTH bits. The add is split over two pipeline stages: the low half is
//   added in stage 1 and the high half in stage 2. Stage 2 uses the low-half
//   carry that stage 1 registered.
//
//   Optional feature: define CSA_RESOLVE_OVF_EN to add io_out_ovf. It flags
//   results whose exact value does not fit in WIDTH bits.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   io_flush      synchronous kill of every in-flight entry (highest priority)
//   io_in_valid   input pair valid
//   io_in_ready   stage can accept an input pair this cycle
//   io_in_sum     sum vector, bit i has weight 2^i
//   io_in_carry   carry vector, bit i has weight 2^(i+1)
//   io_out_valid  result valid
//   io_out_ready  consumer accepts the result
//   io_out_bits   (sum + (carry << 1)) mod 2^WIDTH
//   io_out_ovf    exact sum >= 2^WIDTH (only with CSA_RESOLVE_OVF_EN)
module csa_resolve_stage #(
  parameter int WIDTH = 10,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_sum,
  input  logic [WIDTH-1:0] io_in_carry,
  output logic             io_out_valid,
  input  logic             io_out_ready,
`ifdef CSA_RESOLVE_OVF_EN
  output logic             io_out_ovf,
`endif
  output logic [WIDTH-1:0] io_out_bits
);

  localparam int HI_W = WIDTH - LO_W;

  logic [WIDTH-1:0] w_b;
  logic [LO_W:0]    w_lo_add;
  logic [HI_W:0]    w_hi_add;
  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_in_fire;

  logic             r_s1_valid;
  logic [LO_W-1:0]  r_s1_lo;
  logic             r_s1_c;
  logic [HI_W-1:0]  r_s1_sum_hi;
  logic [HI_W-1:0]  r_s1_b_hi;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out_bits;

  // The carry vector is pre-shifted. Its MSB falls off the top of the
  // WIDTH-bit result.
  assign w_b = {io_in_carry[WIDTH-2:0], 1'b0};

  assign w_lo_add = {1'b0, io_in_sum[LO_W-1:0]} + {1'b0, w_b[LO_W-1:0]};
  assign w_hi_add = {1'b0, r_s1_sum_hi} + {1'b0, r_s1_b_hi} + {{HI_W{1'b0}}, r_s1_c};

  assign w_s2_free   = !r_s2_valid || io_out_ready;
  assign w_s1_adv    = r_s1_valid && w_s2_free;
  assign io_in_ready = !r_s1_valid || w_s2_free;
  assign w_in_fire   = io_in_valid && io_in_ready;

  assign io_out_valid = r_s2_valid;
  assign io_out_bits  = r_out_bits;

`ifdef CSA_RESOLVE_OVF_EN
  logic r_s1_cmsb;
  logic r_out_ovf;

  assign io_out_ovf = r_out_ovf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_cmsb <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (!io_flush) begin
      if (w_in_fire) r_s1_cmsb <= io_in_carry[WIDTH-1];
      // The exact sum overflows if the high half carries out, or if the
      // dropped carry MSB (weight 2^WIDTH) was set.
      if (w_s1_adv) r_out_ovf <= w_hi_add[HI_W] | r_s1_cmsb;
    end
  end
`else
  logic w_unused_carry_msb;
  assign w_unused_carry_msb = io_in_carry[WIDTH-1];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_lo     <= '0;
      r_s1_c      <= 1'b0;
      r_s1_sum_hi <= '0;
      r_s1_b_hi   <= '0;
      r_s2_valid  <= 1'b0;
      r_out_bits  <= '0;
    end else if (io_flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid  <= 1'b1;
        r_s1_lo     <= w_lo_add[LO_W-1:0];
        r_s1_c      <= w_lo_add[LO_W];
        r_s1_sum_hi <= io_in_sum[WIDTH-1:LO_W];
        r_s1_b_hi   <= w_b[WIDTH-1:LO_W];
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_out_bits <= {w_hi_add[HI_W-1:0], r_s1_lo};
      end else if (io_out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_resolve_stage.sv
module tb_csa_resolve_stage;
  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         io_flush = 1'b0;
  logic         io_in_valid = 1'b0;
  logic         io_in_ready;
  logic [W-1:0] io_in_sum = '0;
  logic [W-1:0] io_in_carry = '0;
  logic         io_out_valid;
  logic         io_out_ready = 1'b0;
  logic [W-1:0] io_out_bits;
`ifdef CSA_RESOLVE_OVF_EN
  logic         io_out_ovf;
`endif

  csa_resolve_stage #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .io_flush(io_flush),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_sum(io_in_sum),
    .io_in_carry(io_in_carry),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
`ifdef CSA_RESOLVE_OVF_EN
    .io_out_ovf(io_out_ovf),
`endif
    .io_out_bits(io_out_bits)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] bits;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   n_valid_cycles = 0;
  bit   chk_lat = 1'b0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Exact arithmetic in a wide integer. The result is the value modulo 2^W,
  // and overflow means the value is 2^W or more.
  function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] c);
    int unsigned ex;
    exp_t e;
    ex     = int'(s) + 2 * int'(c);
    e.bits = W'(ex % (1 << W));
    e.ovf  = (ex >= (1 << W));
    e.cyc  = 0;
    return e;
  endfunction

  // Scoreboard monitor. It checks outputs first, then applies a flush, then
  // records newly accepted inputs.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      q.delete();
    end else begin
      if (io_out_valid) n_valid_cycles++;
      if (io_out_valid && io_out_ready && !io_flush) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(io_out_bits), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("out_bits", 32'(io_out_bits), 32'(e.bits));
`ifdef CSA_RESOLVE_OVF_EN
          chk("out_ovf", 32'(io_out_ovf), 32'(e.ovf));
`endif
          if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
          n_out++;
        end
      end
      if (io_flush) q.delete();
      if (io_in_valid && io_in_ready && !io_flush) begin
        e     = model(io_in_sum, io_in_carry);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  // Called just after a rising edge. Returns just after the edge on which the
  // pair was accepted.
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
    int t;
    io_in_sum   = s;
    io_in_carry = c;
    io_in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!io_in_ready && t < 100);
    if (t >= 100) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || io_out_valid) && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    if (t >= 200) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic directed(input string name, input logic [W-1:0] s, input logic [W-1:0] c,
                          input logic [W-1:0] bits, input logic ovf);
    send(s, c);
    @(negedge clock);
    chk({name, "_valid_early"}, 32'(io_out_valid), 32'd0);
    @(negedge clock);
    chk({name, "_valid"}, 32'(io_out_valid), 32'd1);
    chk({name, "_bits"}, 32'(io_out_bits), 32'(bits));
`ifdef CSA_RESOLVE_OVF_EN
    chk({name, "_ovf"}, 32'(io_out_ovf), 32'(ovf));
`else
    if (ovf === 1'bx) chk({name, "_ovf_x"}, 32'd0, 32'd1);
`endif
    @(posedge clock); #1;
    drain();
  endtask

  initial begin
    int start_out, start_valid, accepted;
    bit ready_dropped;
    logic [W-1:0] held;

    // Reset state, checked both under reset and after release.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 32'(io_out_valid), 32'd0);
    chk("rst_out_bits", 32'(io_out_bits), 32'd0);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", 32'(io_in_ready), 32'd1);
    chk("rst_out_valid_rel", 32'(io_out_valid), 32'd0);
    @(posedge clock); #1;

    // Directed values with no backpressure.
    io_out_ready = 1'b1;
    chk_lat = 1'b1;
    directed("t1", 10'h155, 10'h0AA, 10'h2A9, 1'b0);
    directed("t2", 10'h3FF, 10'h3FF, 10'h3FD, 1'b1);
    directed("t2b", 10'h01F, 10'h001, 10'h021, 1'b0);

    // Back-to-back random stream.
    start_out = n_out;
    start_valid = n_valid_cycles;
    ready_dropped = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(W'($urandom), W'($urandom));
      if (!io_in_ready) ready_dropped = 1'b1;
    end
    drain();
    chk("stream_in_ready_dropped", 32'(ready_dropped), 32'd0);
    chk("stream_outputs", 32'(n_out - start_out), 32'd8);
    chk("stream_valid_cycles", 32'(n_valid_cycles - start_valid), 32'd8);

    // Backpressure: out_ready is low for 5 cycles while the source keeps offering.
    chk_lat = 1'b0;
    io_out_ready = 1'b0;
    start_out = n_out;
    accepted = 0;
    held = '0;
    io_in_sum = W'($urandom);
    io_in_carry = W'($urandom);
    io_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (io_out_valid && i == 2) held = io_out_bits;
      if (io_in_ready) accepted++;
      @(posedge clock); #1;
      if (accepted > 0) begin
        io_in_sum = W'($urandom);
        io_in_carry = W'($urandom);
      end
    end
    @(negedge clock);
    chk("stall_accepted", 32'(accepted), 32'd2);
    chk("stall_in_ready", 32'(io_in_ready), 32'd0);
    chk("stall_out_valid", 32'(io_out_valid), 32'd1);
    chk("stall_bits_stable", 32'(io_out_bits), 32'(held));
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    io_out_ready = 1'b1;
    drain();
    chk("stall_released", 32'(n_out - start_out), 32'd2);

    // Flush while the pipeline is full, with a concurrent offer.
    io_out_ready = 1'b0;
    send(W'($urandom), W'($urandom));
    send(W'($urandom), W'($urandom));
    start_out = n_out;
    io_flush = 1'b1;
    io_in_valid = 1'b1;
    io_in_sum = 10'h123;
    io_in_carry = 10'h045;
    @(posedge clock); #1;
    io_flush = 1'b0;
    io_in_valid = 1'b0;
    @(negedge clock);
    chk("flush_out_valid", 32'(io_out_valid), 32'd0);
    chk("flush_in_ready", 32'(io_in_ready), 32'd1);
    @(posedge clock); #1;
    io_out_ready = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("flush_no_outputs", 32'(n_out - start_out), 32'd0);
    chk_lat = 1'b1;
    directed("post_flush", 10'h0F0, 10'h00F, 10'h10E, 1'b0);

    // Asynchronous reset while both stages hold data.
    io_out_ready = 1'b0;
    send(W'($urandom), 10'h3FF);
    send(W'($urandom), W'($urandom));
    #3 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(io_out_valid), 32'd0);
    chk("async_rst_bits", 32'(io_out_bits), 32'd0);
`ifdef CSA_RESOLVE_OVF_EN
    chk("async_rst_ovf", 32'(io_out_ovf), 32'd0);
`endif
    @(negedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", 32'(io_in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(io_out_valid), 32'd0);
    @(posedge clock); #1;
    io_out_ready = 1'b1;
    directed("post_rst", 10'h001, 10'h001, 10'h003, 1'b0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
